press_count_arbiter: RTL

- Controller for the shared push-button event counter on the Nexys4DDR board.
- Debounces three board buttons (up, down, clear) against an internally generated 1 ms tick.
- Converts each debounced press into a single request, and arbitrates the requests onto one shared WIDTH-bit counter.
- Replaces free-running slow-clock sampling with a single-clock-domain, enable-based design driving LED[15:0].

---
 rtl/press_count_pkg.sv | 28 ++
 rtl/press_count_arbiter_btn_debounce_fsm.sv | 93 +++++++++
 rtl/press_count_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/press_count_pkg.sv
// press_count_pkg
// Shared definitions for the push-button event counter controller:
//   - debounce FSM state encoding
//   - button index constants used to address the {C,D,U} vectors
//   - round-robin pointer encoding for the up/down arbiter
//   - default tick divider and debounce length for the 100 MHz board clock
package press_count_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } dbState_e;

  typedef enum logic {
    RR_UP   = 1'b0,
    RR_DOWN = 1'b1
  } rrPtr_e;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_C = 2;

  localparam int DEFAULT_TICK_DIV       = 100000;
  localparam int DEFAULT_DEBOUNCE_TICKS = 20;

endpackage

// File: rtl/press_count_arbiter_btn_debounce_fsm.sv
// btn_debounce_fsm
// Debounces one raw, asynchronous push button. The button is brought into
// the clock domain through a 2-FF synchronizer, then a four-state FSM that
// only advances on sample ticks requires DEBOUNCE_TICKS consecutive equal
// samples before accepting a press or a release.
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   tick_i      one-cycle sample enable
//   btn_i       raw button level (asynchronous)
//   level_o     debounced level (high in PRESSED and RELEASE_WAIT)
//   pressEvt_o  one-cycle combinational pulse in the tick cycle that accepts a press
module btn_debounce_fsm
  import press_count_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic pressEvt_o
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1_q, sync2_q;
  dbState_e      state_q, state_d;
  logic [CW-1:0] stableCnt_q, stableCnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      stableCnt_q <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      stableCnt_q <= stableCnt_d;
    end
  end

  // The stable counter holds the number of equal samples already seen, so
  // the sample that would make it reach DEBOUNCE_TICKS is the accepting one.
  always_comb begin
    state_d     = state_q;
    stableCnt_d = stableCnt_q;
    pressEvt_o  = 1'b0;
    if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_d     = PRESS_WAIT;
            stableCnt_d = CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q) begin
            state_d = IDLE;
          end else if (stableCnt_q == LAST_CNT) begin
            state_d    = PRESSED;
            pressEvt_o = 1'b1;
          end else begin
            stableCnt_d = stableCnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync2_q) begin
            state_d     = RELEASE_WAIT;
            stableCnt_d = CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q) begin
            state_d = PRESSED;
          end else if (stableCnt_q == LAST_CNT) begin
            state_d = IDLE;
          end else begin
            stableCnt_d = stableCnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/press_count_arbiter.sv
// press_count_arbiter
// Shared push-button event counter controller. Generates a sample tick from
// the system clock, debounces up/down/clear buttons, latches each accepted
// press as a pending request and arbitrates one request per cycle onto a
// WIDTH-bit counter. Clear has priority; up and down alternate round-robin
// whenever both are pending.
// Optional feature macro: PRESS_COUNT_SATURATE_EN (saturating count instead
// of modular wrap; grants still pulse when the count cannot move).
// Ports:
//   CLK100MHZ   sole clock
//   RST         asynchronous active-high reset
//   BTNU/BTND/BTNC  raw buttons
//   count       counter value
//   grant_up/grant_down/grant_clr  one-cycle grant pulses
//   btn_level   debounced levels {C,D,U}
module press_count_arbiter
  import press_count_pkg::*;
#(
  parameter int TICK_DIV       = DEFAULT_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int WIDTH          = 16
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             BTNU,
  input  logic             BTND,
  input  logic             BTNC,
  output logic [WIDTH-1:0] count,
  output logic             grant_up,
  output logic             grant_down,
  output logic             grant_clr,
  output logic [2:0]       btn_level
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tickCnt_q, tickCnt_d;
  logic             tick;
  logic [2:0]       pressEvt;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       drop;
  rrPtr_e           rrPtr_q, rrPtr_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             grantUp, grantDown, grantClr;

  assign tick      = (tickCnt_q == TICK_LAST);
  assign tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);

  btn_debounce_fsm #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) uBtnU (
    .clk_i(CLK100MHZ), .rst_i(RST), .tick_i(tick), .btn_i(BTNU),
    .level_o(btn_level[BTN_U]), .pressEvt_o(pressEvt[BTN_U])
  );

  btn_debounce_fsm #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) uBtnD (
    .clk_i(CLK100MHZ), .rst_i(RST), .tick_i(tick), .btn_i(BTND),
    .level_o(btn_level[BTN_D]), .pressEvt_o(pressEvt[BTN_D])
  );

  btn_debounce_fsm #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) uBtnC (
    .clk_i(CLK100MHZ), .rst_i(RST), .tick_i(tick), .btn_i(BTNC),
    .level_o(btn_level[BTN_C]), .pressEvt_o(pressEvt[BTN_C])
  );

  // Grants come straight from the pending register, so a request latched
  // at edge E is granted in the following cycle and applied at E+1.
  always_comb begin
    grantClr  = pend_q[BTN_C];
    grantUp   = !pend_q[BTN_C] && pend_q[BTN_U] &&
                (!pend_q[BTN_D] || (rrPtr_q == RR_UP));
    grantDown = !pend_q[BTN_C] && pend_q[BTN_D] &&
                (!pend_q[BTN_U] || (rrPtr_q == RR_DOWN));

    // A clear grant also drops any pending up/down; a press accepted in the
    // same cycle still sets its bit because the set is ORed in last.
    drop   = {grantClr, grantDown | grantClr, grantUp | grantClr};
    pend_d = (pend_q & ~drop) | pressEvt;

    // The pointer only moves on contended grants, handing the next tie to
    // the side that just lost.
    rrPtr_d = rrPtr_q;
    if (!grantClr && pend_q[BTN_U] && pend_q[BTN_D]) begin
      rrPtr_d = grantUp ? RR_DOWN : RR_UP;
    end

    count_d = count_q;
    if (grantClr) begin
      count_d = '0;
    end else if (grantUp) begin
`ifdef PRESS_COUNT_SATURATE_EN
      count_d = (count_q == {WIDTH{1'b1}}) ? count_q : count_q + WIDTH'(1);
`else
      count_d = count_q + WIDTH'(1);
`endif
    end else if (grantDown) begin
`ifdef PRESS_COUNT_SATURATE_EN
      count_d = (count_q == '0) ? count_q : count_q - WIDTH'(1);
`else
      count_d = count_q - WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      tickCnt_q <= '0;
      pend_q    <= '0;
      rrPtr_q   <= RR_UP;
      count_q   <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
      pend_q    <= pend_d;
      rrPtr_q   <= rrPtr_d;
      count_q   <= count_d;
    end
  end

  assign count      = count_q;
  assign grant_up   = grantUp;
  assign grant_down = grantDown;
  assign grant_clr  = grantClr;

endmodule
